// File: rtl/aer_receiver_if.sv
// AER receive-side bundle: sender request/ack pair plus the downstream event stream.
// With AER_TIMESTAMP_EN defined the bundle also carries the head-entry timestamp ev_ts.
interface aer_receiver_if #(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned LVL_W  = 3
`ifdef AER_TIMESTAMP_EN
    ,
    parameter int unsigned TS_W   = 16
`endif
);
    logic              req;
    logic [ADDR_W-1:0] addr_in;
    logic              ack;
    logic              ev_valid;
    logic [ADDR_W-1:0] ev_addr;
    logic              ev_ready;
    logic [LVL_W-1:0]  fifo_level;
    logic              stall;
`ifdef AER_TIMESTAMP_EN
    logic [TS_W-1:0]   ev_ts;
`endif

    // Receiver side of the link
    modport slave (
        input  req, addr_in, ev_ready,
        output ack, ev_valid, ev_addr, fifo_level, stall
`ifdef AER_TIMESTAMP_EN
        ,
        output ev_ts
`endif
    );

    // Sender plus downstream consumer side
    modport master (
        output req, addr_in, ev_ready,
        input  ack, ev_valid, ev_addr, fifo_level, stall
`ifdef AER_TIMESTAMP_EN
        ,
        input  ev_ts
`endif
    );
endinterface

// File: rtl/aer_receiver.sv
// AER receiver: synchronises the 4-phase request, captures the address, returns ack,
// and queues captured events in a small FIFO drained over valid/ready.
// Optional macro AER_TIMESTAMP_EN adds a free-running timestamp stored with each event.
module aer_receiver #(
    parameter int unsigned ADDR_W      = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TS_W        = 16
) (
    input  logic          clk,
    input  logic          reset,
    aer_receiver_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACK  = 1'b1;

    // Elaboration-time parameter sanity checks
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("aer_receiver: SYNC_STAGES must be at least 2");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("aer_receiver: DEPTH must be a power of 2 and at least 2");
    end
    if (TS_W == 0) begin : g_chk_ts
        $error("aer_receiver: TS_W must be at least 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;

    logic [0:0]             state_q, state_d;
    logic                   ack_q, ack_d;
    logic                   push_c, stall_c, full_c;

    logic                   cap_vld_q;
    logic [ADDR_W-1:0]      cap_addr_q;

    logic [ADDR_W-1:0]      mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]       level_q;
    logic                   wr_en_c, rd_en_c, valid_c;

    // Request synchroniser into the clk domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.req};
        end
    end

    assign req_s  = sync_q[SYNC_STAGES-1];
    assign full_c = (level_q == LVL_W'(DEPTH));

    // Handshake FSM state and ack registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    // Next-state logic: capture once per handshake, hold off while the FIFO is full
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        push_c  = 1'b0;
        stall_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    if (!full_c) begin
                        push_c  = 1'b1;
                        ack_d   = 1'b1;
                        state_d = ACK;
                    end else begin
                        stall_c = 1'b1;
                    end
                end
            end
            ACK: begin
                ack_d = 1'b1;
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture register: address is sampled on the IDLE->ACK transition and written next cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_vld_q  <= 1'b0;
            cap_addr_q <= '0;
        end else begin
            cap_vld_q <= push_c;
            if (push_c) begin
                cap_addr_q <= bus.addr_in;
            end
        end
    end

    assign valid_c = (level_q != '0);
    assign wr_en_c = cap_vld_q;
    assign rd_en_c = valid_c && bus.ev_ready;

    // FIFO storage (no reset; output is masked while empty)
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr_q] <= cap_addr_q;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_en_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (rd_en_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({wr_en_c, rd_en_c})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

`ifdef AER_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;
    logic [TS_W-1:0] cap_ts_q;
    logic [TS_W-1:0] ts_mem [DEPTH];

    // Free-running timestamp and its capture alongside the address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q     <= '0;
            cap_ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
            if (push_c) begin
                cap_ts_q <= ts_q;
            end
        end
    end

    // Timestamp storage parallel to the address FIFO
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            ts_mem[wr_ptr_q] <= cap_ts_q;
        end
    end

    assign bus.ev_ts = valid_c ? ts_mem[rd_ptr_q] : '0;
`endif

    assign bus.ack        = ack_q;
    assign bus.stall      = stall_c;
    assign bus.ev_valid   = valid_c;
    assign bus.ev_addr    = valid_c ? mem[rd_ptr_q] : '0;
    assign bus.fifo_level = level_q;
endmodule

// File: tb/tb_aer_receiver.sv
// Directed self-checking bench for aer_receiver.
// Inputs are driven and outputs sampled 1 time unit after each rising clock edge.
module tb_aer_receiver;
    localparam int unsigned ADDR_W      = 2;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned DEPTH       = 4;
`ifdef AER_TIMESTAMP_EN
    localparam int unsigned TS_W        = 4;
`else
    localparam int unsigned TS_W        = 16;
`endif
    localparam int unsigned LVL_W       = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passed = 0;

    aer_receiver_if #(
        .ADDR_W(ADDR_W),
        .LVL_W (LVL_W)
`ifdef AER_TIMESTAMP_EN
        ,
        .TS_W  (TS_W)
`endif
    ) bus ();

    aer_receiver #(
        .ADDR_W     (ADDR_W),
        .SYNC_STAGES(SYNC_STAGES),
        .DEPTH      (DEPTH),
        .TS_W       (TS_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full 4-phase handshake with bounded waits; ok=0 if ack never rose or never fell
    task automatic hs(input logic [1:0] a, output bit ok);
        int n;
        ok = 1'b1;
        bus.addr_in = a;
        bus.req = 1'b1;
        n = 0;
        while (bus.ack !== 1'b1 && n < 20) begin tick(); n++; end
        if (bus.ack !== 1'b1) ok = 1'b0;
        bus.req = 1'b0;
        n = 0;
        while (bus.ack !== 1'b0 && n < 20) begin tick(); n++; end
        if (bus.ack !== 1'b0) ok = 1'b0;
    endtask

    task automatic test_reset();
        bus.req = 1'b0; bus.addr_in = 2'd0; bus.ev_ready = 1'b0;
        reset = 1'b1;
        tick(); tick();
        checks++; if (bus.ack !== 1'b0) $display("FAIL reset_ack: got %b expected 0", bus.ack); else passed++;
        checks++; if (bus.ev_valid !== 1'b0) $display("FAIL reset_ev_valid: got %b expected 0", bus.ev_valid); else passed++;
        checks++; if (bus.ev_addr !== 2'd0) $display("FAIL reset_ev_addr: got %0d expected 0", bus.ev_addr); else passed++;
        checks++; if (bus.fifo_level !== 3'd0) $display("FAIL reset_level: got %0d expected 0", bus.fifo_level); else passed++;
        checks++; if (bus.stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", bus.stall); else passed++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_event();
        bus.ev_ready = 1'b1;
        bus.addr_in = 2'b10;
        bus.req = 1'b1;                         // cycle 0
        tick(); tick();                         // cycle 2
        checks++; if (bus.ack !== 1'b0) $display("FAIL single_ack_c2: got %b expected 0", bus.ack); else passed++;
        tick();                                 // cycle 3
        checks++; if (bus.ack !== 1'b1) $display("FAIL single_ack_c3: got %b expected 1", bus.ack); else passed++;
        checks++; if (bus.ev_valid !== 1'b0) $display("FAIL single_valid_c3: got %b expected 0", bus.ev_valid); else passed++;
        tick();                                 // cycle 4
        checks++; if (bus.ev_valid !== 1'b1) $display("FAIL single_valid_c4: got %b expected 1", bus.ev_valid); else passed++;
        checks++; if (bus.ev_addr !== 2'd2) $display("FAIL single_addr_c4: got %0d expected 2", bus.ev_addr); else passed++;
        tick();                                 // cycle 5, popped; ev_ready still high while empty
        checks++; if (bus.ev_valid !== 1'b0) $display("FAIL single_valid_c5: got %b expected 0", bus.ev_valid); else passed++;
        checks++; if (bus.fifo_level !== 3'd0) $display("FAIL single_level_c5: got %0d expected 0", bus.fifo_level); else passed++;
        bus.req = 1'b0;
        tick(); tick();
        checks++; if (bus.ack !== 1'b1) $display("FAIL single_ack_fall_c2: got %b expected 1", bus.ack); else passed++;
        tick();
        checks++; if (bus.ack !== 1'b0) $display("FAIL single_ack_fall_c3: got %b expected 0", bus.ack); else passed++;
        checks++; if (bus.fifo_level !== 3'd0) $display("FAIL single_no_underflow: got %0d expected 0", bus.fifo_level); else passed++;
        bus.ev_ready = 1'b0;
    endtask

    task automatic test_back_pressure();
        bit ok;
        int n;
        logic [1:0] exp_addr [4];
        exp_addr = '{2'd1, 2'd2, 2'd3, 2'd2};
        bus.ev_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hs(2'(i), ok);
            checks++; if (!ok) $display("FAIL bp_handshake_%0d: got timeout expected ack cycle", i); else passed++;
        end
        tick();
        checks++; if (bus.fifo_level !== 3'd4) $display("FAIL bp_level_full: got %0d expected 4", bus.fifo_level); else passed++;
        bus.addr_in = 2'd2;
        bus.req = 1'b1;
        repeat (6) tick();
        checks++; if (bus.ack !== 1'b0) $display("FAIL bp_ack_withheld: got %b expected 0", bus.ack); else passed++;
        checks++; if (bus.stall !== 1'b1) $display("FAIL bp_stall: got %b expected 1", bus.stall); else passed++;
        checks++; if (bus.ev_addr !== 2'd0) $display("FAIL bp_head0: got %0d expected 0", bus.ev_addr); else passed++;
        bus.ev_ready = 1'b1;
        tick();
        bus.ev_ready = 1'b0;
        checks++; if (bus.fifo_level !== 3'd3) $display("FAIL bp_level_after_pop: got %0d expected 3", bus.fifo_level); else passed++;
        checks++; if (bus.ack !== 1'b0) $display("FAIL bp_no_push_same_cycle: got %b expected 0", bus.ack); else passed++;
        tick();
        checks++; if (bus.ack !== 1'b1) $display("FAIL bp_ack_resume: got %b expected 1", bus.ack); else passed++;
        checks++; if (bus.stall !== 1'b0) $display("FAIL bp_stall_clear: got %b expected 0", bus.stall); else passed++;
        bus.req = 1'b0;
        n = 0;
        while (bus.ack !== 1'b0 && n < 20) begin tick(); n++; end
        checks++; if (bus.ack !== 1'b0) $display("FAIL bp_ack_release: got %b expected 0", bus.ack); else passed++;
        checks++; if (bus.fifo_level !== 3'd4) $display("FAIL bp_level_refill: got %0d expected 4", bus.fifo_level); else passed++;
        bus.ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.ev_valid !== 1'b1 || bus.ev_addr !== exp_addr[i])
                $display("FAIL bp_drain_%0d: got valid=%b addr=%0d expected valid=1 addr=%0d", i, bus.ev_valid, bus.ev_addr, exp_addr[i]);
            else passed++;
            tick();
        end
        bus.ev_ready = 1'b0;
        checks++; if (bus.fifo_level !== 3'd0) $display("FAIL bp_level_empty: got %0d expected 0", bus.fifo_level); else passed++;
    endtask

    task automatic test_held_request();
        int drops;
        drops = 0;
        bus.ev_ready = 1'b0;
        bus.addr_in = 2'd3;
        bus.req = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (i >= 2 && bus.ack !== 1'b1) drops++;
        end
        checks++; if (drops !== 0) $display("FAIL held_ack_drops: got %0d expected 0", drops); else passed++;
        checks++; if (bus.fifo_level !== 3'd1) $display("FAIL held_level: got %0d expected 1", bus.fifo_level); else passed++;
        checks++; if (bus.ev_addr !== 2'd3) $display("FAIL held_addr: got %0d expected 3", bus.ev_addr); else passed++;
        bus.req = 1'b0;
        tick(); tick(); tick();
        checks++; if (bus.ack !== 1'b0) $display("FAIL held_ack_fall: got %b expected 0", bus.ack); else passed++;
        checks++; if (bus.fifo_level !== 3'd1) $display("FAIL held_level_after: got %0d expected 1", bus.fifo_level); else passed++;
        bus.ev_ready = 1'b1;
        tick();
        bus.ev_ready = 1'b0;
    endtask

    task automatic test_simultaneous();
        bit ok;
        int n;
        bus.ev_ready = 1'b0;
        hs(2'd1, ok);
        checks++; if (!ok) $display("FAIL sim_hs1: got timeout expected ack cycle"); else passed++;
        hs(2'd2, ok);
        checks++; if (!ok) $display("FAIL sim_hs2: got timeout expected ack cycle"); else passed++;
        tick();
        checks++; if (bus.fifo_level !== 3'd2) $display("FAIL sim_level_pre: got %0d expected 2", bus.fifo_level); else passed++;
        bus.addr_in = 2'd3;
        bus.req = 1'b1;
        tick(); tick(); tick();
        checks++; if (bus.ack !== 1'b1) $display("FAIL sim_ack: got %b expected 1", bus.ack); else passed++;
        bus.ev_ready = 1'b1;                     // pop lands on the FIFO write edge
        tick();
        bus.ev_ready = 1'b0;
        checks++; if (bus.fifo_level !== 3'd2) $display("FAIL sim_level_same: got %0d expected 2", bus.fifo_level); else passed++;
        checks++; if (bus.ev_addr !== 2'd2) $display("FAIL sim_head: got %0d expected 2", bus.ev_addr); else passed++;
        bus.req = 1'b0;
        n = 0;
        while (bus.ack !== 1'b0 && n < 20) begin tick(); n++; end
        checks++; if (bus.ack !== 1'b0) $display("FAIL sim_ack_release: got %b expected 0", bus.ack); else passed++;
        bus.ev_ready = 1'b1;
        checks++; if (bus.ev_addr !== 2'd2) $display("FAIL sim_drain0: got %0d expected 2", bus.ev_addr); else passed++;
        tick();
        checks++; if (bus.ev_addr !== 2'd3) $display("FAIL sim_drain1: got %0d expected 3", bus.ev_addr); else passed++;
        tick();
        bus.ev_ready = 1'b0;
        checks++; if (bus.fifo_level !== 3'd0) $display("FAIL sim_level_end: got %0d expected 0", bus.fifo_level); else passed++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        bus.ev_ready = 1'b0;
        bus.addr_in = 2'd2;
        bus.req = 1'b1;
        tick(); tick(); tick();
        checks++; if (bus.ack !== 1'b1) $display("FAIL rmid_ack_pre: got %b expected 1", bus.ack); else passed++;
        tick();
        checks++; if (bus.ev_valid !== 1'b1) $display("FAIL rmid_valid_pre: got %b expected 1", bus.ev_valid); else passed++;
        #2;
        reset = 1'b1;                            // asserted between clock edges
        #1;
        checks++; if (bus.ack !== 1'b0) $display("FAIL rmid_ack_async: got %b expected 0", bus.ack); else passed++;
        checks++; if (bus.ev_valid !== 1'b0) $display("FAIL rmid_valid_async: got %b expected 0", bus.ev_valid); else passed++;
        checks++; if (bus.fifo_level !== 3'd0) $display("FAIL rmid_level_async: got %0d expected 0", bus.fifo_level); else passed++;
        bus.req = 1'b0;
        #1;
        reset = 1'b0;
        tick();
        hs(2'd1, ok);
        checks++; if (!ok) $display("FAIL rmid_hs: got timeout expected ack cycle"); else passed++;
        checks++; if (bus.ev_valid !== 1'b1 || bus.ev_addr !== 2'd1)
            $display("FAIL rmid_new_event: got valid=%b addr=%0d expected valid=1 addr=1", bus.ev_valid, bus.ev_addr);
        else passed++;
        bus.ev_ready = 1'b1;
        tick();
        bus.ev_ready = 1'b0;
    endtask

`ifdef AER_TIMESTAMP_EN
    task automatic test_timestamp();
        bus.req = 1'b0; bus.ev_ready = 1'b0;
        reset = 1'b1;
        tick();
        checks++; if (bus.ev_ts !== 4'd0) $display("FAIL ts_reset: got %0d expected 0", bus.ev_ts); else passed++;
        reset = 1'b0;                            // counter reads n after the n-th edge from here
        repeat (12) tick();
        bus.addr_in = 2'd1;
        bus.req = 1'b1;                          // captured at edge 15 with counter value 14
        tick(); tick(); tick();
        bus.req = 1'b0;
        repeat (17) tick();                      // edge 32
        bus.addr_in = 2'd3;
        bus.req = 1'b1;                          // captured at edge 35 with counter value 34 mod 16 = 2
        tick(); tick(); tick();
        bus.req = 1'b0;
        tick(); tick(); tick();
        checks++; if (bus.ev_addr !== 2'd1 || bus.ev_ts !== 4'd14)
            $display("FAIL ts_first: got addr=%0d ts=%0d expected addr=1 ts=14", bus.ev_addr, bus.ev_ts);
        else passed++;
        bus.ev_ready = 1'b1;
        tick();
        bus.ev_ready = 1'b0;
        checks++; if (bus.ev_addr !== 2'd3 || bus.ev_ts !== 4'd2)
            $display("FAIL ts_second: got addr=%0d ts=%0d expected addr=3 ts=2", bus.ev_addr, bus.ev_ts);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_event();
        test_back_pressure();
        test_held_request();
        test_simultaneous();
        test_reset_mid();
`ifdef AER_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
